load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-side load/store unit: consumes the memory control fields the main decoder produces (MemWrite, 2-bit AccessMode) together with the address and store data. It performs byte, halfword or word accesses on a word-wide, request/grant data-memory bus and returns sign-extended load data to the core. Misaligned halfword and word accesses are split into two bus beats. It sits between the core datapath and data memory.

## Interface
- `ADDR_W`, 32, byte-address width
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  core presents an access
- `req_ready`  out  1  unit idle, can accept
- `req_write`  in  1  1 = store (MemWrite), 0 = load
- `access_mode`  in  2  00 byte, 01 half, 10 word, 11 reserved
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  32  store data, LSB-justified
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_err`  out  1  valid with rsp_valid; reserved mode
- `rsp_rdata`  out  32  sign-extended load data, valid with rsp_valid
- `bus_req`  out  1  bus request, held until grant
- `bus_we`  out  1  write beat
- `bus_addr`  out  ADDR_W  word-aligned address, low 2 bits = 0
- `bus_be`  out  4  byte enables
- `bus_wdata`  out  32  lane-aligned write data
- `bus_gnt`  in  1  beat accepted this cycle
- `bus_rvalid`  in  1  read data valid, at least 1 cycle after gnt
- `bus_rdata`  in  32  read data

## Operation
- Request accepted on `req_valid && req_ready`; all request fields latched that cycle. `req_ready` = 1 only in IDLE.
- Size n = 1/2/4; offset o = `req_addr[1:0]`. Split when o+n > 4: half at o=3; word at o≠0.
- Beat 0: addr {addr[ADDR_W-1:2],00}, be = (2^n−1)<<o truncated to 4 bits, wdata = req_wdata<<8o.
- Beat 1 (split only): addr beat0+4 with wrap modulo 2^ADDR_W, be = (2^n−1)>>(4−o), wdata = req_wdata>>8(4−o).
- Loads: result byte i = beat-0 byte o+i, or beat-1 byte o+i−4 once past lane 3; byte/half sign-extended from bit 7/15. Only signed loads exist.
- Reserved mode 11: no bus activity; rsp_valid with rsp_err=1, rsp_rdata=0.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
  - IDLE→REQ0 on accept; IDLE→RESP on accept with mode 11.
  - REQ0: bus_req=1. On gnt: write→REQ1 if split else RESP; read→WAIT0.
  - WAIT0: on rvalid capture beat 0, then →REQ1 if split else RESP.
  - REQ1/WAIT1: as REQ0/WAIT0 for beat 1, always →RESP.
  - RESP: rsp_valid=1 for one cycle, →IDLE.
- bus_addr/be/we/wdata stable while bus_req=1 and gnt=0. rvalid outside WAIT0/WAIT1 is ignored.

## Timing
- Reset (async, any state): state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0. An in-flight bus beat is abandoned, with no response.
- Accept at cycle t → bus_req at t+1.
- Aligned write with immediate gnt: rsp_valid at t+2.
- Aligned read with gnt at t+1, rvalid at t+2: rsp_valid at t+3.
- Reserved mode: rsp_valid at t+1.
- rsp_* are registered and held until the next RESP. req_ready returns to 1 the cycle after rsp_valid, so there is no back-to-back overlap.

## Structure
- `lsu_pkg`: access-mode enum (AM_BYTE, AM_HALF, AM_WORD, AM_RSVD, values matching the decoder encoding), FSM state enum, size-from-mode function.
- Sub-module `lsu_align`: combinational computation of split flag, per-beat byte enables, shifted write data, and load merge/sign-extension.
- The top level holds the FSM and the registers.

## Test plan
- Aligned lw at 0x100, rdata 0xDEADBEEF, gnt at t+1, rvalid at t+2 → one beat with be=1111; rsp_rdata 0xDEADBEEF at t+3.
- lb at 0x203, rdata 0x80xxxxxx → be=1000; rsp_rdata 0xFFFFFF80. lh at 0x202, rdata 0x7F12xxxx → 0x00007F12.
- Misaligned sw at 0x101, wdata 0x11223344 → beat 0x100 be=1110 wdata 0x22334400; beat 0x104 be=0001 wdata 0x00000011; single rsp.
- Misaligned lh at 0x0FF, beat0 0xAAxxxxxx, beat1 0xxxxxxx81 → rsp_rdata 0xFFFF81AA. At ADDR_W=32, addr 0xFFFFFFFF wraps beat1 to 0x0.
- gnt withheld 5 cycles → bus outputs stable throughout. Mode 11 → rsp_err at t+1, bus_req never asserted.
- rst_n low during WAIT0 → immediate IDLE with all reset values; a later rvalid is ignored; the next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared types and helpers for the data-side load/store unit.
//   access_mode_t : memory access width as encoded by the main decoder
//   lsu_state_t   : bus sequencing FSM states of load_store_unit
//   size_from_mode: number of bytes touched by an access (0 for reserved)
package lsu_pkg;

  typedef enum logic [1:0] {
    AM_BYTE = 2'b00,
    AM_HALF = 2'b01,
    AM_WORD = 2'b10,
    AM_RSVD = 2'b11
  } access_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } lsu_state_t;

  // Byte count of an access. The reserved encoding reports zero bytes so
  // that any lane mask derived from it is empty.
  function automatic logic [2:0] size_from_mode(input logic [1:0] mode);
    logic [2:0] size;
    case (mode)
      AM_BYTE: size = 3'd1;
      AM_HALF: size = 3'd2;
      AM_WORD: size = 3'd4;
      default: size = 3'd0;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align
// Purely combinational lane steering for the load/store unit.
// Ports:
//   access_mode : 2-bit access width (byte/half/word/reserved)
//   offset      : byte offset of the access inside its word
//   wdata       : LSB-justified store data
//   rdata0      : read data of beat 0
//   rdata1      : read data of beat 1 (only meaningful for split loads)
//   split       : access crosses a word boundary and needs two beats
//   be0/be1     : byte enables of beat 0 / beat 1
//   wdata0/1    : lane-aligned write data of beat 0 / beat 1
//   load_data   : merged, sign-extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  access_mode,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata0,
  input  logic [31:0] rdata1,
  output logic        split,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] load_data
);

  logic [2:0]  size;
  logic [3:0]  mask;
  logic [4:0]  shamt;
  logic [7:0]  be_wide;
  logic [63:0] wide_w;
  logic [31:0] raw;

  // The two beats are treated as one 64-bit window: shifting the lane mask
  // and the store data left by the offset puts beat-0 lanes in the low half
  // and the spill-over lanes of beat 1 in the high half. Loads run the same
  // window the other way, so result byte i comes from window byte o+i,
  // which is beat 0 up to lane 3 and beat 1 after it.
  always_comb begin
    size = size_from_mode(access_mode);
    case (size)
      3'd1:    mask = 4'b0001;
      3'd2:    mask = 4'b0011;
      3'd4:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    split   = (({1'b0, offset} + size) > 3'd4);
    shamt   = {offset, 3'b000};
    be_wide = {4'b0000, mask} << offset;
    be0     = be_wide[3:0];
    be1     = be_wide[7:4];
    wide_w  = {32'h0000_0000, wdata} << shamt;
    wdata0  = wide_w[31:0];
    wdata1  = wide_w[63:32];
    raw     = 32'({rdata1, rdata0} >> shamt);
    case (access_mode)
      AM_BYTE: load_data = {{24{raw[7]}}, raw[7:0]};
      AM_HALF: load_data = {{16{raw[15]}}, raw[15:0]};
      AM_WORD: load_data = raw;
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Data-side load/store unit. Takes one byte/half/word access from the core,
// runs it as one or two word-aligned beats on a request/grant data bus and
// returns a one-cycle response with sign-extended load data.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : core request handshake (ready only when idle)
//   req_write           : 1 = store, 0 = load
//   access_mode         : 00 byte, 01 half, 10 word, 11 reserved
//   req_addr/req_wdata  : byte address, LSB-justified store data
//   rsp_valid           : one-cycle completion pulse
//   rsp_err/rsp_rdata   : reserved-mode error flag, load result (held)
//   bus_req/bus_gnt     : beat request, held until granted
//   bus_we/bus_addr     : beat direction and word-aligned address
//   bus_be/bus_wdata    : byte enables and lane-aligned write data
//   bus_rvalid/rdata    : read data return for load beats
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        access_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  lsu_state_t        state, state_d;
  logic              write_q;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata0_q;
  logic [ADDR_W-1:0] beat0_addr, beat1_addr;
  logic              accept;
  logic              cap0;
  logic              rsp_load;
  logic              rsp_err_d;
  logic [31:0]       rsp_rdata_d;
  logic [31:0]       rd0_src;
  logic              split;
  logic [3:0]        be0, be1;
  logic [31:0]       wdata0, wdata1;
  logic [31:0]       load_data;

  // Beat 1 sits one word above beat 0; the add wraps naturally at the top
  // of the address space because it is ADDR_W bits wide.
  assign beat0_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign beat1_addr = beat0_addr + ADDR_W'(4);
  assign accept     = req_valid && (state == ST_IDLE);

  // While waiting for beat 0 the merge uses the live bus data so the
  // response can be registered in the same cycle rvalid arrives. Beat 1 is
  // always consumed live, so only beat 0 ever needs to be stored.
  always_comb begin
    rd0_src = (state == ST_WAIT0) ? bus_rdata : rdata0_q;
  end

  lsu_align u_align (
    .access_mode (mode_q),
    .offset      (addr_q[1:0]),
    .wdata       (wdata_q),
    .rdata0      (rd0_src),
    .rdata1      (bus_rdata),
    .split       (split),
    .be0         (be0),
    .be1         (be1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .load_data   (load_data)
  );

  // Next-state and output decode. Bus fields are driven purely from
  // registered state, so they stay stable for as long as a beat waits for
  // its grant, and read as zero whenever no beat is requested. rsp_load
  // marks the transition into RESP, where the response registers update.
  always_comb begin
    state_d     = state;
    cap0        = 1'b0;
    rsp_load    = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0000_0000;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = '0;
    bus_be      = 4'b0000;
    bus_wdata   = 32'h0000_0000;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (access_mode == AM_RSVD) begin
            state_d   = ST_RESP;
            rsp_load  = 1'b1;
            rsp_err_d = 1'b1;
          end else begin
            state_d = ST_REQ0;
          end
        end
      end
      ST_REQ0: begin
        bus_req   = 1'b1;
        bus_we    = write_q;
        bus_addr  = beat0_addr;
        bus_be    = be0;
        bus_wdata = write_q ? wdata0 : 32'h0000_0000;
        if (bus_gnt) begin
          if (!write_q) begin
            state_d = ST_WAIT0;
          end else if (split) begin
            state_d = ST_REQ1;
          end else begin
            state_d  = ST_RESP;
            rsp_load = 1'b1;
          end
        end
      end
      ST_WAIT0: begin
        if (bus_rvalid) begin
          cap0 = 1'b1;
          if (split) begin
            state_d = ST_REQ1;
          end else begin
            state_d     = ST_RESP;
            rsp_load    = 1'b1;
            rsp_rdata_d = load_data;
          end
        end
      end
      ST_REQ1: begin
        bus_req   = 1'b1;
        bus_we    = write_q;
        bus_addr  = beat1_addr;
        bus_be    = be1;
        bus_wdata = write_q ? wdata1 : 32'h0000_0000;
        if (bus_gnt) begin
          if (write_q) begin
            state_d  = ST_RESP;
            rsp_load = 1'b1;
          end else begin
            state_d = ST_WAIT1;
          end
        end
      end
      ST_WAIT1: begin
        if (bus_rvalid) begin
          state_d     = ST_RESP;
          rsp_load    = 1'b1;
          rsp_rdata_d = load_data;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers. Request fields are captured on accept,
  // beat-0 read data on its rvalid, and the response on entry to RESP;
  // the response then holds until the next one. Reset drops any beat in
  // flight without producing a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      write_q   <= 1'b0;
      mode_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= 32'h0000_0000;
      rdata0_q  <= 32'h0000_0000;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
    end else begin
      state <= state_d;
      if (accept) begin
        write_q <= req_write;
        mode_q  <= access_mode;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (cap0) begin
        rdata0_q <= bus_rdata;
      end
      if (rsp_load) begin
        rsp_err   <= rsp_err_d;
        rsp_rdata <= rsp_rdata_d;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Directed bench for load_store_unit: each access is issued, every bus
// beat is checked against hand-computed address/enables/data, and the
// response is checked on its exact cycle.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  access_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int vecCount  = 0;
  int missCount = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .access_mode (access_mode),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_rdata   (rsp_rdata),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_gnt     (bus_gnt),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if the sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every vector and reports mismatches.
  task automatic checkOutput(input string tag, input logic [79:0] observed,
                             input logic [79:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to 1 ns after the next rising edge, where inputs are driven
  // and outputs sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; on return the bench sits in
  // the cycle after acceptance.
  task automatic applyStimulus(input string tag, input logic write,
                               input logic [1:0] mode, input logic [31:0] addr,
                               input logic [31:0] wdata);
    checkOutput({tag, ".ready"}, 80'(req_ready), 80'(1'b1));
    req_valid   = 1'b1;
    req_write   = write;
    access_mode = mode;
    req_addr    = addr;
    req_wdata   = wdata;
    tick();
    req_valid   = 1'b0;
    req_write   = 1'b0;
    access_mode = 2'b00;
    req_addr    = 32'h0;
    req_wdata   = 32'h0;
  endtask

  // Check one bus beat (held stable across a stall), grant it, and for
  // loads return read data the cycle after the grant.
  task automatic serveBeat(input string tag, input logic we,
                           input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input int stall,
                           input logic [31:0] rdata);
    logic [31:0] obsData;
    for (int i = 0; i <= stall; i++) begin
      obsData = we ? bus_wdata : 32'h0;
      checkOutput($sformatf("%s.beat%0d", tag, i),
                  80'({bus_req, bus_we, bus_be, bus_addr, obsData}),
                  80'({1'b1, we, be, addr, (we ? wdata : 32'h0)}));
      if (i < stall) tick();
    end
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    if (!we) begin
      checkOutput({tag, ".wait"}, 80'(bus_req), 80'(1'b0));
      bus_rvalid = 1'b1;
      bus_rdata  = rdata;
      tick();
      bus_rvalid = 1'b0;
      bus_rdata  = 32'h0;
    end
  endtask

  // Check the response pulse, then that it lasts one cycle and the unit
  // is ready again.
  task automatic checkResponse(input string tag, input logic err,
                               input logic [31:0] rdata, input bit chkData);
    checkOutput({tag, ".rsp"}, 80'({rsp_valid, rsp_err, req_ready}),
                80'({1'b1, err, 1'b0}));
    if (chkData) checkOutput({tag, ".rdata"}, 80'(rsp_rdata), 80'(rdata));
    tick();
    checkOutput({tag, ".after"}, 80'({rsp_valid, req_ready, bus_req}),
                80'({1'b0, 1'b1, 1'b0}));
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    access_mode = 2'b00;
    req_addr    = 32'h0;
    req_wdata   = 32'h0;
    bus_gnt     = 1'b0;
    bus_rvalid  = 1'b0;
    bus_rdata   = 32'h0;
    repeat (3) tick();

    checkOutput("reset.ctl",
                80'({req_ready, rsp_valid, rsp_err, bus_req, bus_we, bus_be}),
                80'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}));
    checkOutput("reset.data", 80'({bus_addr, bus_wdata}), 80'(64'h0));
    checkOutput("reset.rdata", 80'(rsp_rdata), 80'(32'h0));
    rst_n = 1'b1;
    tick();

    applyStimulus("lw100", 1'b0, 2'b10, 32'h0000_0100, 32'h0);
    serveBeat("lw100", 1'b0, 32'h0000_0100, 4'b1111, 32'h0, 0, 32'hDEAD_BEEF);
    checkResponse("lw100", 1'b0, 32'hDEAD_BEEF, 1'b1);

    applyStimulus("lb203", 1'b0, 2'b00, 32'h0000_0203, 32'h0);
    serveBeat("lb203", 1'b0, 32'h0000_0200, 4'b1000, 32'h0, 0, 32'h8012_3456);
    checkResponse("lb203", 1'b0, 32'hFFFF_FF80, 1'b1);

    applyStimulus("lh202", 1'b0, 2'b01, 32'h0000_0202, 32'h0);
    serveBeat("lh202", 1'b0, 32'h0000_0200, 4'b1100, 32'h0, 0, 32'h7F12_ABCD);
    checkResponse("lh202", 1'b0, 32'h0000_7F12, 1'b1);

    applyStimulus("sw101", 1'b1, 2'b10, 32'h0000_0101, 32'h1122_3344);
    serveBeat("sw101.b0", 1'b1, 32'h0000_0100, 4'b1110, 32'h2233_4400, 0, 32'h0);
    serveBeat("sw101.b1", 1'b1, 32'h0000_0104, 4'b0001, 32'h0000_0011, 0, 32'h0);
    checkResponse("sw101", 1'b0, 32'h0, 1'b0);

    applyStimulus("lh0ff", 1'b0, 2'b01, 32'h0000_00FF, 32'h0);
    serveBeat("lh0ff.b0", 1'b0, 32'h0000_00FC, 4'b1000, 32'h0, 0, 32'hAA00_0000);
    serveBeat("lh0ff.b1", 1'b0, 32'h0000_0100, 4'b0001, 32'h0, 0, 32'h0000_0081);
    checkResponse("lh0ff", 1'b0, 32'hFFFF_81AA, 1'b1);

    applyStimulus("lhwrap", 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0);
    serveBeat("lhwrap.b0", 1'b0, 32'hFFFF_FFFC, 4'b1000, 32'h0, 0, 32'h3400_0000);
    serveBeat("lhwrap.b1", 1'b0, 32'h0000_0000, 4'b0001, 32'h0, 0, 32'h0000_0012);
    checkResponse("lhwrap", 1'b0, 32'h0000_1234, 1'b1);

    applyStimulus("sw203", 1'b1, 2'b10, 32'h0000_0203, 32'hA1B2_C3D4);
    serveBeat("sw203.b0", 1'b1, 32'h0000_0200, 4'b1000, 32'hD400_0000, 0, 32'h0);
    serveBeat("sw203.b1", 1'b1, 32'h0000_0204, 4'b0111, 32'h00A1_B2C3, 0, 32'h0);
    checkResponse("sw203", 1'b0, 32'h0, 1'b0);

    applyStimulus("sb002", 1'b1, 2'b00, 32'h0000_0002, 32'h0000_00AB);
    serveBeat("sb002", 1'b1, 32'h0000_0000, 4'b0100, 32'h00AB_0000, 0, 32'h0);
    checkResponse("sb002", 1'b0, 32'h0, 1'b0);

    applyStimulus("shstall", 1'b1, 2'b01, 32'h0000_0006, 32'h1234_BEEF);
    serveBeat("shstall", 1'b1, 32'h0000_0004, 4'b1100, 32'hBEEF_0000, 5, 32'h0);
    checkResponse("shstall", 1'b0, 32'h0, 1'b0);

    applyStimulus("rsvd", 1'b0, 2'b11, 32'h0000_0040, 32'h0);
    checkOutput("rsvd.nobus", 80'(bus_req), 80'(1'b0));
    checkResponse("rsvd", 1'b1, 32'h0, 1'b1);
    checkOutput("rsvd.hold", 80'(rsp_err), 80'(1'b1));

    applyStimulus("rstw0", 1'b0, 2'b10, 32'h0000_0300, 32'h0);
    checkOutput("rstw0.req", 80'(bus_req), 80'(1'b1));
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    checkOutput("rstw0.wait", 80'({bus_req, req_ready}), 80'({1'b0, 1'b0}));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstw0.ctl",
                80'({req_ready, rsp_valid, rsp_err, bus_req, bus_we, bus_be}),
                80'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}));
    checkOutput("rstw0.data", 80'({bus_addr, bus_wdata}), 80'(64'h0));
    checkOutput("rstw0.rdata", 80'(rsp_rdata), 80'(32'h0));
    #1;
    rst_n = 1'b1;
    tick();
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hCAFE_F00D;
    tick();
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0;
    checkOutput("rstw0.ignored", 80'({rsp_valid, req_ready, bus_req}),
                80'({1'b0, 1'b1, 1'b0}));

    applyStimulus("lw104", 1'b0, 2'b10, 32'h0000_0104, 32'h0);
    serveBeat("lw104", 1'b0, 32'h0000_0104, 4'b1111, 32'h0, 0, 32'h1234_5678);
    checkResponse("lw104", 1'b0, 32'h1234_5678, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
